// File: rtl/timer_run_controller.sv
// Microwave timer run controller: keypad MM:SS entry, 1 Hz BCD countdown,
// pause/clear handling, done hold, timer source-select and magnetron enable.
module timer_run_controller #(
    parameter int DONE_TICKS = 3,
    parameter int TICK_W     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    output logic       load_sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       mag_on,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    localparam logic [TICK_W-1:0] HOLD_LAST = TICK_W'(DONE_TICKS - 1);

    state_t            state;
    state_t            state_next;
    bcd_time_t         digits;
    bcd_time_t         digits_next;
    bcd_time_t         digits_dec;
    bcd_time_t         digits_shift;
    logic [TICK_W-1:0] hold_cnt;
    logic [TICK_W-1:0] hold_next;
    logic              key_ok;
    logic              time_zero;
    logic              dec_zero;
    logic              door_open;

    assign key_ok    = key_valid && (key_digit <= 4'd9);
    assign time_zero = (digits == '0);
    assign dec_zero  = (digits_dec == '0);
    assign door_open = !door_closed;

    // Keypad entry shifts the display left; the old minutes-tens digit falls off.
    assign digits_shift = '{
        min_tens: digits.min_ones,
        min_ones: digits.sec_tens,
        sec_tens: digits.sec_ones,
        sec_ones: key_digit
    };

    // One-second BCD decrement. A borrow into the seconds tens reloads 5, so an
    // entered 60-99 seconds field still counts down through its own values.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        digits_dec = digits;
        if (digits.sec_ones != 4'd0) begin
            digits_dec.sec_ones = digits.sec_ones - 4'd1;
        end else begin
            digits_dec.sec_ones = 4'd9;
            if (digits.sec_tens != 4'd0) begin
                digits_dec.sec_tens = digits.sec_tens - 4'd1;
            end else begin
                digits_dec.sec_tens = 4'd5;
                if (digits.min_ones != 4'd0) begin
                    digits_dec.min_ones = digits.min_ones - 4'd1;
                end else begin
                    digits_dec.min_ones = 4'd9;
                    digits_dec.min_tens = digits.min_tens - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_next  = state;
        digits_next = digits;
        hold_next   = hold_cnt;

        unique case (state)
            ST_IDLE: begin
                if (stop_clear) begin
                    digits_next = '0;
                end else if (start && door_closed && !time_zero) begin
                    state_next = ST_RUN;
                end else if (key_ok) begin
                    digits_next = digits_shift;
                end
            end

            ST_RUN: begin
                if (stop_clear || door_open) begin
                    state_next = ST_PAUSED;
                end else if (tick_1hz) begin
                    // Zero time never reaches RUN; the guard keeps the count from wrapping regardless.
                    if (time_zero || dec_zero) begin
                        digits_next = '0;
                        state_next  = ST_DONE;
                        hold_next   = '0;
                    end else begin
                        digits_next = digits_dec;
                    end
                end
            end

            ST_PAUSED: begin
                if (stop_clear) begin
                    state_next  = ST_IDLE;
                    digits_next = '0;
                end else if (start && door_closed) begin
                    state_next = ST_RUN;
                end
            end

            ST_DONE: begin
                digits_next = '0;
                if (stop_clear || door_open) begin
                    state_next = ST_IDLE;
                    hold_next  = '0;
                end else if (tick_1hz) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_next = ST_IDLE;
                        hold_next  = '0;
                    end else begin
                        hold_next = hold_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_next  = ST_IDLE;
                digits_next = '0;
                hold_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state    <= ST_IDLE;
            digits   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            digits   <= digits_next;
            hold_cnt <= hold_next;
        end
    end

    // The door term is deliberately combinational so the magnetron drops the moment the door opens.
    assign load_sel = (state == ST_RUN);
    assign mag_on   = load_sel && door_closed;
    assign done     = (state == ST_DONE);

    assign min_tens = digits.min_tens;
    assign min_ones = digits.min_ones;
    assign sec_tens = digits.sec_tens;
    assign sec_ones = digits.sec_ones;

endmodule

// File: doc/timer_run_controller.md
Name: timer_run_controller

Overview:
- Sequences the microwave timer datapath: keypad entry of an MM:SS BCD time, countdown on a 1 Hz enable, and pause, clear and done handling.
- Drives the timer's 2:1 source-select (keypad load path vs. decrement path) and the magnetron enable.
- Sits between the keypad decoder / door sensor and the display / power stage.

Parameters:
- DONE_TICKS, 3, number of tick_1hz pulses that done stays high before the block returns to IDLE.
- TICK_W, 2, width of the done-hold counter; must satisfy 2^TICK_W > DONE_TICKS.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- tick_1hz  input  1  one-cycle enable pulse, once per second.
- key_valid  input  1  one-cycle strobe; key_digit is valid while it is high.
- key_digit  input  4  BCD digit 0-9; values 10-15 are ignored.
- start  input  1  start/resume request, level-sampled each cycle.
- stop_clear  input  1  pause (in RUN) or clear (otherwise), level-sampled each cycle.
- door_closed  input  1  1 = door closed.
- load_sel  output  1  timer mux select: 0 = keypad load path, 1 = decrement path.
- min_tens  output  4  BCD minutes tens.
- min_ones  output  4  BCD minutes ones.
- sec_tens  output  4  BCD seconds tens.
- sec_ones  output  4  BCD seconds ones.
- mag_on  output  1  magnetron enable.
- done  output  1  cook-complete indicator.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, all four digits=0, done-hold counter=0, mag_on=0, done=0, load_sel=0. rst overrides every other input.
- States: IDLE, RUN, PAUSED, DONE. All outputs are registered or decoded from registered state. Response to any input appears 1 cycle after the sampling edge.
- Decoded outputs:
  - load_sel=1 only in RUN.
  - mag_on=1 only in RUN with door_closed=1. The door term is combinational, so mag_on drops in the same cycle the door opens.
  - done=1 only in DONE.
- Input priority within one cycle: stop_clear > door-open > start > tick_1hz > key_valid.
- IDLE:
  - Valid key (key_valid=1, key_digit<=9) shifts digits left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit. The old min_tens is discarded.
  - Invalid digits are ignored.
  - stop_clear zeroes all digits.
  - start with door_closed=1 and a nonzero time -> RUN. start with a zero time or door open is ignored.
- RUN:
  - Keys are ignored.
  - stop_clear -> PAUSED. door_closed=0 -> PAUSED. Digits are held in both cases.
  - tick_1hz decrements by one second, in BCD:
    - If sec_ones>0, sec_ones-1.
    - Else sec_ones=9 and borrow from sec_tens. If sec_tens>0, sec_tens-1.
    - Else sec_tens=5 and borrow from minutes: min_ones-1, or min_ones=9 with min_tens-1.
  - Entered sec_tens values 6-9 are legal and count down normally; only a borrow reloads 5.
  - If the decrement result is 00:00 -> DONE on the same edge, with the done-hold counter cleared.
  - A tick coinciding with stop_clear or door-open is not applied.
- PAUSED:
  - Keys are ignored. Ticks are ignored.
  - stop_clear -> IDLE with digits zeroed.
  - start with door_closed=1 -> RUN. start with the door open stays PAUSED.
- DONE:
  - Digits stay 00:00.
  - Each tick increments the done-hold counter. On the tick that brings it to DONE_TICKS -> IDLE and the counter clears.
  - stop_clear or door_closed=0 -> IDLE immediately.
  - start and keys are ignored.
- Digits never hold values >9. Minute range is 00-99. Countdown never goes below 00:00 (no wrap).
- A state is held indefinitely absent qualifying inputs.

Test Plan:
- Reset, then keys 1,3,0 -> digits 01:30, load_sel=0, mag_on=0. Fifth key 7 after 1,2,3,4 -> 23:47. Key 12 -> no change.
- 00:03, door closed, start -> RUN next cycle, load_sel=1, mag_on=1. Ticks -> 00:02, 00:01, 00:00. On the 00:00 edge: DONE, done=1, mag_on=0. After 3 further ticks -> IDLE, done=0.
- Borrow chain: 10:00 in RUN, one tick -> 09:59. 01:00 -> 00:59. 00:90 (entered) -> 00:89.
- RUN at 00:45, door opened in the same cycle as a tick -> mag_on=0 immediately, PAUSED, digits stay 00:45. start with the door open -> still PAUSED. Close door + start -> RUN, counting resumes from 00:45.
- RUN: stop_clear -> PAUSED with digits held. stop_clear again -> IDLE with 00:00. start at 00:00 -> stays IDLE, mag_on=0.
- rst asserted mid-RUN at 05:12 -> next cycle IDLE, 00:00, all outputs 0. start and stop_clear asserted together in PAUSED -> IDLE, cleared.
